// File: rtl/memory_arbiter_if.sv
// Requester-side handshake bundle for memory_arbiter.
// Two requesters: req/rw/addr/wdata toward the arbiter, ack/rdata back.
interface memory_arbiter_if #(
    parameter int address_size = 16
);
    logic                    req0;
    logic                    req1;
    logic                    rw0;
    logic                    rw1;
    logic [address_size-1:0] addr0;
    logic [address_size-1:0] addr1;
    logic [15:0]             wdata0;
    logic [15:0]             wdata1;
    logic                    ack0;
    logic                    ack1;
    logic [15:0]             rdata0;
    logic [15:0]             rdata1;

    modport master (
        output req0, req1, rw0, rw1,
        output addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, rw0, rw1,
        input  addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter for a single-port memory.
// IDLE -> ACCESS -> DONE; one access every three cycles.
module memory_arbiter #(
    parameter int address_size = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    memory_arbiter_if.slave         req_if,
    output logic                    mem_enable,
    output logic                    mem_read_write,
    output logic [address_size-1:0] mem_address,
    inout  wire  [15:0]             mem_data,
    output logic                    busy,
    output logic                    grant_id
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]              state;
    logic                    last_id;
    logic                    lat_rw;
    logic [address_size-1:0] lat_addr;
    logic [15:0]             lat_wdata;
    logic [15:0]             rdata0_q;
    logic [15:0]             rdata1_q;
    logic                    any_req;
    logic                    winner;
    logic                    in_access;
    logic                    drive_wr;

    assign any_req = req_if.req0 | req_if.req1;

    // Contention goes to whoever was not served last.
    always_comb begin
        winner = 1'b0;
        if (req_if.req0 && req_if.req1)
            winner = ~last_id;
        else if (req_if.req1)
            winner = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= 1'b0;
            last_id   <= 1'b1;
            lat_rw    <= 1'b1;
            lat_addr  <= '0;
            lat_wdata <= 16'h0000;
            rdata0_q  <= 16'h0000;
            rdata1_q  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        last_id  <= winner;
                        if (winner) begin
                            lat_rw    <= req_if.rw1;
                            lat_addr  <= req_if.addr1;
                            lat_wdata <= req_if.wdata1;
                        end else begin
                            lat_rw    <= req_if.rw0;
                            lat_addr  <= req_if.addr0;
                            lat_wdata <= req_if.wdata0;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_rw) begin
                        if (grant_id)
                            rdata1_q <= mem_data;
                        else
                            rdata0_q <= mem_data;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_access      = (state == ACCESS);
    assign drive_wr       = in_access & ~lat_rw;
    assign mem_enable     = in_access;
    assign mem_read_write = ~drive_wr;
    assign mem_address    = in_access ? lat_addr : '0;
    assign mem_data       = drive_wr ? lat_wdata : 16'hzzzz;
    assign busy           = (state != IDLE);

    assign req_if.ack0   = (state == DONE) & ~grant_id;
    assign req_if.ack1   = (state == DONE) & grant_id;
    assign req_if.rdata0 = rdata0_q;
    assign req_if.rdata1 = rdata1_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level model plus directed checks.
// Environment memory answers reads and commits writes on the bus.
module tb_memory_arbiter;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    memory_arbiter_if #(.address_size(AW)) bus();

    logic          mem_enable;
    logic          mem_read_write;
    logic [AW-1:0] mem_address;
    wire  [15:0]   mem_data;
    logic          busy;
    logic          grant_id;

    memory_arbiter #(.address_size(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_if        (bus),
        .mem_enable    (mem_enable),
        .mem_read_write(mem_read_write),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    // External memory seen by the arbiter
    bit [15:0] mem_arr [0:65535];
    assign mem_data = (mem_enable && mem_read_write) ? mem_arr[mem_address] : 16'hzzzz;
    always @(posedge clk)
        if (mem_enable && !mem_read_write)
            mem_arr[mem_address] <= mem_data;

    int n_chk = 0;
    int n_pass = 0;
    int ack1_cnt = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: age counts cycles since the grant (-1 = no access).
    int        age = -1;
    bit        m_gid = 1'b0;
    bit        m_last = 1'b1;
    bit        m_rw = 1'b1;
    bit [15:0] m_addr = 16'h0;
    bit [15:0] m_wdata = 16'h0;
    bit [15:0] m_rd0 = 16'h0;
    bit [15:0] m_rd1 = 16'h0;
    bit [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (reset) begin
            if (age == 0 && !m_rw)
                ref_mem[m_addr] = m_wdata;
            age = -1;
            m_gid = 1'b0;
            m_last = 1'b1;
            m_rd0 = 16'h0;
            m_rd1 = 16'h0;
        end else if (age == 0) begin
            if (!m_rw)
                ref_mem[m_addr] = m_wdata;
            else if (m_gid)
                m_rd1 = ref_mem[m_addr];
            else
                m_rd0 = ref_mem[m_addr];
            age = 1;
        end else if (age == 1) begin
            age = -1;
        end else if (bus.req0 || bus.req1) begin
            if (bus.req0 && bus.req1)
                m_gid = !m_last;
            else
                m_gid = bus.req1;
            m_last = m_gid;
            m_rw = m_gid ? bus.rw1 : bus.rw0;
            m_addr = m_gid ? bus.addr1 : bus.addr0;
            m_wdata = m_gid ? bus.wdata1 : bus.wdata0;
            age = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, age >= 0);
            chk("mem_enable", mem_enable, age == 0);
            chk("mem_read_write", mem_read_write, (age == 0) ? m_rw : 1'b1);
            chk("mem_address", mem_address, (age == 0) ? m_addr : 16'h0);
            chk("ack0", bus.ack0, age == 1 && !m_gid);
            chk("ack1", bus.ack1, age == 1 && m_gid);
            chk("grant_id", grant_id, m_gid);
            chk("rdata0", bus.rdata0, m_rd0);
            chk("rdata1", bus.rdata1, m_rd1);
            if (age == 0)
                chk("mem_data", mem_data, m_rw ? mem_arr[m_addr] : m_wdata);
        end
        if (bus.ack1 === 1'b1)
            ack1_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input bit id, input bit v, input bit rw,
                           input logic [15:0] a, input logic [15:0] d);
        if (id) begin
            bus.req1 = v; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = v; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // One isolated access from IDLE; ack must appear two cycles after req.
    task automatic xfer(input bit id, input bit rw, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rd);
        int lat;
        lat = 0;
        set_req(id, 1'b1, rw, a, d);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if ((id ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("xfer_latency", lat, 2);
        rd = id ? bus.rdata1 : bus.rdata0;
        set_req(id, 1'b0, rw, a, d);
        tick(1);
    endtask

    logic [15:0] rd;
    int          got_id[$];
    int          got_cyc[$];
    logic [15:0] got_rd[$];
    int          snap;

    initial begin
        set_req(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b1, 16'h0, 16'h0);
        tick(2);
        chk_on = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_rw", mem_read_write, 1'b1);
        chk("rst_mem_addr", mem_address, 16'h0);
        chk("rst_grant", grant_id, 1'b0);
        chk("rst_rdata0", bus.rdata0, 16'h0);
        reset = 1'b0;
        tick(1);

        // Write then read back on requester 0
        xfer(1'b0, 1'b0, 16'h0010, 16'hBEEF, rd);
        xfer(1'b0, 1'b1, 16'h0010, 16'h0000, rd);
        chk("t1_rdata0", rd, 16'hBEEF);
        chk("t1_ack1_never", ack1_cnt, 0);

        // Contended, held requests after reset alternate 0,1,0,1
        xfer(1'b0, 1'b0, 16'h0040, 16'hAAAA, rd);
        xfer(1'b1, 1'b0, 16'h0041, 16'h5555, rd);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0);
        set_req(1'b1, 1'b1, 1'b1, 16'h0041, 16'h0);
        for (int c = 1; c <= 20 && got_id.size() < 4; c++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1) begin
                got_id.push_back(0); got_cyc.push_back(c); got_rd.push_back(bus.rdata0);
            end
            if (bus.ack1 === 1'b1) begin
                got_id.push_back(1); got_cyc.push_back(c); got_rd.push_back(bus.rdata1);
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick(1);
        chk("t2_ack_count", got_id.size(), 4);
        for (int k = 0; k < 4 && k < got_id.size(); k++) begin
            chk("t2_grant_order", got_id[k], k % 2);
            chk("t2_rdata", got_rd[k], (k % 2) ? 16'h5555 : 16'hAAAA);
            if (k > 0)
                chk("t2_spacing", got_cyc[k] - got_cyc[k-1], 3);
        end

        // Attribute change during ACCESS has no effect
        set_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1111);
        tick(1);
        bus.addr0 = 16'h0030;
        bus.wdata0 = 16'h2222;
        tick(1);
        chk("t3_ack0", bus.ack0, 1'b1);
        bus.req0 = 1'b0;
        tick(1);
        chk("t3_mem_latched", mem_arr[16'h0020], 16'h1111);
        chk("t3_mem_untouched", mem_arr[16'h0030], 16'h0000);

        // Reset during a write ACCESS: write lands, no ack
        set_req(1'b0, 1'b1, 1'b0, 16'h0005, 16'h1234);
        tick(1);
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick(1);
        chk("t4_no_ack0", bus.ack0, 1'b0);
        chk("t4_idle", busy, 1'b0);
        chk("t4_rdata0", bus.rdata0, 16'h0);
        chk("t4_mem", mem_arr[16'h0005], 16'h1234);
        reset = 1'b0;
        tick(1);
        xfer(1'b0, 1'b1, 16'h0005, 16'h0000, rd);
        chk("t4_readback", rd, 16'h1234);

        // One-cycle req1 pulse while busy is never served
        set_req(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0777);
        tick(1);
        set_req(1'b1, 1'b1, 1'b1, 16'h0007, 16'h0);
        tick(1);
        bus.req1 = 1'b0;
        chk("t5_ack0", bus.ack0, 1'b1);
        bus.req0 = 1'b0;
        snap = ack1_cnt;
        tick(4);
        chk("t5_no_ack1", ack1_cnt, snap);

        // Top-of-range address passes through unmodified
        xfer(1'b1, 1'b0, 16'hFFFF, 16'hA5A5, rd);
        xfer(1'b1, 1'b1, 16'hFFFF, 16'h0000, rd);
        chk("t6_rdata1", rd, 16'hA5A5);
        chk("t6_mem", mem_arr[16'hFFFF], 16'hA5A5);

        // Random traffic, checked every cycle by the model
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1)
                bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 2) == 0)
                set_req(1'b0, 1'b1, 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 15)), 16'($urandom));
            if (bus.ack1 === 1'b1)
                bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 2) == 0)
                set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 15)), 16'($urandom));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick(4);
        chk("t7_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: address_size, default 16, width of every address port.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  access request from requester 0 / 1.
REQ-005 rw0 / rw1  input  1  1 = read, 0 = write, sampled with req.
REQ-006 addr0 / addr1  input  address_size  requested memory address.
REQ-007 wdata0 / wdata1  input  16  write data, used only when rw = 0.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 rdata0 / rdata1  output  16  registered read data, valid while the matching ack is high.
REQ-010 mem_enable  output  1  memory enable.
REQ-011 mem_read_write  output  1  1 = read, 0 = write.
REQ-012 mem_address  output  address_size  memory address.
REQ-013 mem_data  inout  16  bidirectional memory data bus.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 grant_id  output  1  index of the requester currently owning the bus; holds its last value while IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-017 IDLE: if either req is high, the FSM SHALL latch the winner's rw, addr and wdata into internal registers, set grant_id and move to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: if only one req is high, that requester wins; if both are high, the requester not served last wins.
REQ-019 The last-served pointer SHALL update only on entry to ACCESS.
REQ-020 ACCESS: the block SHALL drive mem_enable = 1, mem_read_write = latched rw and mem_address = latched addr for exactly one cycle, then move to DONE.
REQ-021 Write in ACCESS: mem_data SHALL be driven with the latched wdata. The memory commits the write at the posedge that ends ACCESS.
REQ-022 Read in ACCESS: mem_data SHALL be high-Z at the arbiter, and the value on mem_data SHALL be captured into the granted requester's rdata at the posedge that ends ACCESS.
REQ-023 In every state other than ACCESS-write, the arbiter SHALL leave mem_data high-Z.
REQ-024 Outside ACCESS, mem_enable SHALL be 0 and mem_read_write SHALL be 1, so the bus is never driven with a write.
REQ-025 DONE: ack[grant_id] SHALL be high for exactly one cycle and the other ack low; the FSM SHALL then return to IDLE.
REQ-026 rdata SHALL hold its value until the next read for that requester. rdata SHALL NOT change on a write.
REQ-027 Latency: req sampled high in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2. Throughput is one access per 3 cycles.
REQ-028 Requester attributes SHALL be sampled only in IDLE. Changes to rw, addr or wdata after the grant SHALL have no effect on the access in flight.
REQ-029 A req dropped before it is sampled in IDLE SHALL NOT be served. There is no queuing.
REQ-030 A requester SHALL deassert req on the edge where it sees ack. A req still high in the next IDLE cycle SHALL be treated as a new request.
REQ-031 A req asserted while busy = 1 SHALL be held by the requester and served in the next IDLE cycle, subject to round-robin.
REQ-032 Address values SHALL pass through unmodified; the arbiter SHALL NOT range-check or wrap addresses.

Reset
REQ-033 On reset high at a posedge, the FSM SHALL go to IDLE and drive the following: ack0 = ack1 = 0, rdata0 = rdata1 = 0, mem_enable = 0, mem_read_write = 1, mem_address = 0, grant_id = 0, busy = 0, mem_data = Z.
REQ-034 On reset, the last-served pointer SHALL be set to 1, so requester 0 wins the first contended grant.
REQ-035 Reset asserted during ACCESS: the write or read on that same edge completes in the memory, but no ack SHALL be issued and rdata SHALL stay 0.
REQ-036 Reset asserted during DONE SHALL suppress ack from the next cycle onward.

Verification
REQ-037 Single write then read, requester 0: write 0xBEEF to address 0x0010, then read 0x0010. Required response: ack0 two cycles after each req, rdata0 = 0xBEEF, ack1 never high.
REQ-038 Simultaneous requests after reset: req0 and req1 both high and held. Required grant order: 0, 1, 0, 1 on successive accesses, with a new ack every 3 cycles.
REQ-039 Attribute change after grant: change addr0 and wdata0 in the ACCESS cycle. Required response: memory holds the values latched in IDLE, and the new address is untouched.
REQ-040 Bus contention check: over random traffic, mem_data SHALL never be X. The arbiter drives mem_data only when mem_enable = 1 and mem_read_write = 0.
REQ-041 Reset mid-ACCESS on a write of 0x1234 to address 0x0005: no ack is issued, the FSM is in IDLE next cycle, and a subsequent read of 0x0005 returns 0x1234.
REQ-042 Short request: req1 high for one cycle while busy. Required response: never served, and ack1 stays 0.
